// File: rtl/rs_alu_param.sv
// ALU reservation station: collapsing queue of DEPTH entries with NCDB-port CDB
// wakeup, issue bypass, oldest-ready dispatch, back-pressure and flush.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module rs_alu_param #(
    parameter int DEPTH = 4,
    parameter int NCDB  = 2,
    parameter int OP_W  = `ALU_OP_WIDTH,
    parameter int TAG_W = `ROB_ENTRY_WIDTH,
    parameter int XLEN  = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_we,
    input  logic [OP_W-1:0]        Op_in,
    input  logic [XLEN-1:0]        Vj_in,
    input  logic [XLEN-1:0]        Vk_in,
    input  logic [TAG_W-1:0]       Qj_in,
    input  logic [TAG_W-1:0]       Qk_in,
    input  logic [TAG_W-1:0]       Dest_in,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*XLEN-1:0]   cdb_data,
    input  logic                   flush,
    output logic                   full,
    output logic [CW-1:0]          count,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [OP_W-1:0]        Op_out,
    output logic [XLEN-1:0]        Vj_out,
    output logic [XLEN-1:0]        Vk_out,
    output logic [TAG_W-1:0]       Dest_out
);

    logic [DEPTH-1:0]             valid_r;
    logic [DEPTH-1:0][OP_W-1:0]   op_r;
    logic [DEPTH-1:0][XLEN-1:0]   vj_r, vk_r;
    logic [DEPTH-1:0][TAG_W-1:0]  qj_r, qk_r, dest_r;
    logic [CW-1:0]                count_r;
    logic                         full_r;

    logic [DEPTH-1:0]             nxt_valid_s;
    logic [DEPTH-1:0][OP_W-1:0]   nxt_op_s;
    logic [DEPTH-1:0][XLEN-1:0]   nxt_vj_s, nxt_vk_s;
    logic [DEPTH-1:0][TAG_W-1:0]  nxt_qj_s, nxt_qk_s, nxt_dest_s;
    logic [CW-1:0]                nxt_count_s;

    logic [DEPTH:0]               ext_valid_s;
    logic [DEPTH:0][OP_W-1:0]     ext_op_s;
    logic [DEPTH:0][XLEN-1:0]     ext_vj_s, ext_vk_s;
    logic [DEPTH:0][TAG_W-1:0]    ext_qj_s, ext_qk_s, ext_dest_s;

    logic [DEPTH-1:0]             ready_s;
    logic                         any_ready_s;
    logic [IW-1:0]                sel_s;
    logic                         disp_fire_s;
    logic                         issue_fire_s;
    logic [CW-1:0]                wpos_s;
    logic [XLEN:0]                byp_j_s, byp_k_s;
    logic [XLEN-1:0]              in_vj_s, in_vk_s;
    logic [TAG_W-1:0]             in_qj_s, in_qk_s;

    // CDB match: {hit, data}; tag 0 never matches and the lowest port index wins.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]      q,
        input logic [NCDB-1:0]       vld,
        input logic [NCDB*TAG_W-1:0] tags,
        input logic [NCDB*XLEN-1:0]  data
    );
        logic [XLEN:0] res;
        res = '0;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (vld[p] && (q != '0) && (tags[p*TAG_W +: TAG_W] == q)) begin
                res = {1'b1, data[p*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    // Per-slot ready flags and oldest-ready selection.
    always_comb begin
        ready_s = '0;
        sel_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = valid_r[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_s[i]) begin
                sel_s = IW'(i);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign any_ready_s  = |ready_s;
    assign disp_fire_s  = any_ready_s && disp_ready;
    assign issue_fire_s = issue_we && !full_r && !flush;
    assign wpos_s       = count_r - CW'(disp_fire_s);

    assign disp_valid = any_ready_s;
    assign Op_out     = any_ready_s ? op_r[sel_s]   : '0;
    assign Vj_out     = any_ready_s ? vj_r[sel_s]   : '0;
    assign Vk_out     = any_ready_s ? vk_r[sel_s]   : '0;
    assign Dest_out   = any_ready_s ? dest_r[sel_s] : '0;
    assign full       = full_r;
    assign count      = count_r;

    // Issue bypass: operands produced in the issue cycle are captured on entry.
    always_comb begin
        byp_j_s = cdb_lookup(Qj_in, cdb_valid, cdb_tag, cdb_data);
        byp_k_s = cdb_lookup(Qk_in, cdb_valid, cdb_tag, cdb_data);
        if (byp_j_s[XLEN]) begin
            in_qj_s = '0;
            in_vj_s = byp_j_s[XLEN-1:0];
        end else begin
            in_qj_s = Qj_in;
            in_vj_s = Vj_in;
        end
        if (byp_k_s[XLEN]) begin
            in_qk_s = '0;
            in_vk_s = byp_k_s[XLEN-1:0];
        end else begin
            in_qk_s = Qk_in;
            in_vk_s = Vk_in;
        end
    end

    // Slot array padded with one empty slot so the top slot can shift in nothing.
    always_comb begin
        ext_valid_s = '0;
        ext_op_s    = '0;
        ext_vj_s    = '0;
        ext_vk_s    = '0;
        ext_qj_s    = '0;
        ext_qk_s    = '0;
        ext_dest_s  = '0;
        ext_valid_s[DEPTH-1:0] = valid_r;
        ext_op_s[DEPTH-1:0]    = op_r;
        ext_vj_s[DEPTH-1:0]    = vj_r;
        ext_vk_s[DEPTH-1:0]    = vk_r;
        ext_qj_s[DEPTH-1:0]    = qj_r;
        ext_qk_s[DEPTH-1:0]    = qk_r;
        ext_dest_s[DEPTH-1:0]  = dest_r;
    end

    // Next state: collapse over the dispatched slot, wake up, then append the issue.
    always_comb begin
        logic [XLEN:0] hit_j;
        logic [XLEN:0] hit_k;
        int            src;
        nxt_valid_s = '0;
        nxt_op_s    = '0;
        nxt_vj_s    = '0;
        nxt_vk_s    = '0;
        nxt_qj_s    = '0;
        nxt_qk_s    = '0;
        nxt_dest_s  = '0;
        hit_j       = '0;
        hit_k       = '0;
        src         = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire_s && (i >= int'(sel_s))) begin
                src = i + 1;
            end else begin
                src = i;
            end
            nxt_valid_s[i] = ext_valid_s[src];
            nxt_op_s[i]    = ext_op_s[src];
            nxt_dest_s[i]  = ext_dest_s[src];
            hit_j = cdb_lookup(ext_qj_s[src], cdb_valid, cdb_tag, cdb_data);
            hit_k = cdb_lookup(ext_qk_s[src], cdb_valid, cdb_tag, cdb_data);
            if (hit_j[XLEN]) begin
                nxt_qj_s[i] = '0;
                nxt_vj_s[i] = hit_j[XLEN-1:0];
            end else begin
                nxt_qj_s[i] = ext_qj_s[src];
                nxt_vj_s[i] = ext_vj_s[src];
            end
            if (hit_k[XLEN]) begin
                nxt_qk_s[i] = '0;
                nxt_vk_s[i] = hit_k[XLEN-1:0];
            end else begin
                nxt_qk_s[i] = ext_qk_s[src];
                nxt_vk_s[i] = ext_vk_s[src];
            end
            if (issue_fire_s && (i == int'(wpos_s))) begin
                nxt_valid_s[i] = 1'b1;
                nxt_op_s[i]    = Op_in;
                nxt_dest_s[i]  = Dest_in;
                nxt_qj_s[i]    = in_qj_s;
                nxt_vj_s[i]    = in_vj_s;
                nxt_qk_s[i]    = in_qk_s;
                nxt_vk_s[i]    = in_vk_s;
            end else begin
                nxt_valid_s[i] = nxt_valid_s[i];
            end
        end
        if (flush) begin
            nxt_valid_s = '0;
            nxt_count_s = '0;
        end else begin
            nxt_count_s = count_r + CW'(issue_fire_s) - CW'(disp_fire_s);
        end
    end

    // State registers; reset empties the station without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            op_r    <= '0;
            vj_r    <= '0;
            vk_r    <= '0;
            qj_r    <= '0;
            qk_r    <= '0;
            dest_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
        end else begin
            valid_r <= nxt_valid_s;
            op_r    <= nxt_op_s;
            vj_r    <= nxt_vj_s;
            vk_r    <= nxt_vk_s;
            qj_r    <= nxt_qj_s;
            qk_r    <= nxt_qk_s;
            dest_r  <= nxt_dest_s;
            count_r <= nxt_count_s;
            full_r  <= (nxt_count_s == CW'(DEPTH));
        end
    end

endmodule
